// File: rtl/osc_analyzer_pkg.sv
// Shared types and tracker seed values for the oscillator waveform analyzer.
package osc_analyzer_pkg;

  typedef enum logic {SEEK = 1'b0, MEASURE = 1'b1} analyzer_state_t;

  // Most negative value of a signed field; seeds the running maximum.
  function automatic logic signed [63:0] tracker_max_init(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Most positive value of a signed field; seeds the running minimum.
  function automatic logic signed [63:0] tracker_min_init(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

endpackage

// File: rtl/osc_schmitt_edge.sv
// Hysteresis comparator on valid samples; pulses rise in the same cycle as the
// sample that moves the comparator from LOW to HIGH.
module osc_schmitt_edge
  import osc_analyzer_pkg::*;
#(
  parameter int WAVE_WIDTH_P = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [WAVE_WIDTH_P-1:0] wave_sample,
  input  logic                           wave_valid,
  input  logic        [WAVE_WIDTH_P-2:0] cr_hysteresis,
  output logic                           rise
);

  localparam int W = WAVE_WIDTH_P;

  logic              high_r;
  logic              high_n_s;
  logic signed [W:0] sample_ext_s;
  logic signed [W:0] thr_pos_s;
  logic signed [W:0] thr_neg_s;
  logic              above_s;
  logic              below_s;

  // One extra bit keeps -H representable and the compares overflow-free
  always_comb begin
    sample_ext_s = {wave_sample[W-1], wave_sample};
    thr_pos_s    = $signed({2'b00, cr_hysteresis});
    thr_neg_s    = -thr_pos_s;
    above_s      = (sample_ext_s >= thr_pos_s);
    below_s      = (sample_ext_s <= thr_neg_s);
  end

  // Comparator next state and rising-edge pulse
  always_comb begin
    high_n_s = high_r;
    rise     = 1'b0;
    if (wave_valid) begin
      if (!high_r && above_s) begin
        high_n_s = 1'b1;
        rise     = 1'b1;
      end else if (high_r && below_s) begin
        high_n_s = 1'b0;
      end else begin
        high_n_s = high_r;
      end
    end else begin
      high_n_s = high_r;
    end
  end

  // Comparator state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_r <= 1'b0;
    end else begin
      high_r <= high_n_s;
    end
  end

endmodule

// File: rtl/osc_wave_analyzer.sv
// Per-period measurement of a signed oscillator waveform: period in clocks,
// peak, trough and peak-to-peak, plus a sticky loss-of-signal flag.
module osc_wave_analyzer
  import osc_analyzer_pkg::*;
#(
  parameter int WAVE_WIDTH_P   = 24,
  parameter int PERIOD_WIDTH_P = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [WAVE_WIDTH_P-1:0]   wave_sample,
  input  logic                             wave_valid,
  input  logic        [WAVE_WIDTH_P-2:0]   cr_hysteresis,
  input  logic        [PERIOD_WIDTH_P-1:0] cr_timeout,
  output logic                             meas_valid,
  output logic        [PERIOD_WIDTH_P-1:0] meas_period,
  output logic signed [WAVE_WIDTH_P-1:0]   meas_max,
  output logic signed [WAVE_WIDTH_P-1:0]   meas_min,
  output logic        [WAVE_WIDTH_P:0]     meas_p2p,
  output logic                             signal_lost
);

  localparam int W = WAVE_WIDTH_P;
  localparam int P = PERIOD_WIDTH_P;

  localparam logic signed [63:0]  MAX_INIT_WIDE = tracker_max_init(W);
  localparam logic signed [63:0]  MIN_INIT_WIDE = tracker_min_init(W);
  localparam logic signed [W-1:0] MAX_INIT      = MAX_INIT_WIDE[W-1:0];
  localparam logic signed [W-1:0] MIN_INIT      = MIN_INIT_WIDE[W-1:0];
  localparam logic [P-1:0]        CNT_ZERO      = {P{1'b0}};
  localparam logic [P-1:0]        CNT_ONE       = {{(P-1){1'b0}}, 1'b1};
  localparam logic [P-1:0]        CNT_MAX       = {P{1'b1}};

  analyzer_state_t   state_r;
  analyzer_state_t   state_n_s;
  logic [P-1:0]      counter_r;
  logic [P-1:0]      counter_n_s;
  logic [P-1:0]      counter_inc_s;
  logic signed [W-1:0] max_r;
  logic signed [W-1:0] min_r;
  logic signed [W-1:0] max_n_s;
  logic signed [W-1:0] min_n_s;
  logic signed [W-1:0] merged_max_s;
  logic signed [W-1:0] merged_min_s;
  logic [W:0]        span_s;
  logic              rise_s;
  logic              timeout_s;
  logic              valid_n_s;
  logic [P-1:0]      period_n_s;
  logic signed [W-1:0] mmax_n_s;
  logic signed [W-1:0] mmin_n_s;
  logic [W:0]        p2p_n_s;
  logic              lost_n_s;

  osc_schmitt_edge #(
    .WAVE_WIDTH_P (W)
  ) u_schmitt (
    .clk           (clk),
    .rst_n         (rst_n),
    .wave_sample   (wave_sample),
    .wave_valid    (wave_valid),
    .cr_hysteresis (cr_hysteresis),
    .rise          (rise_s)
  );

  // Trackers merged with the current sample, saturating counter step, timeout test
  always_comb begin
    merged_max_s  = (wave_sample > max_r) ? wave_sample : max_r;
    merged_min_s  = (wave_sample < min_r) ? wave_sample : min_r;
    span_s        = {merged_max_s[W-1], merged_max_s} - {merged_min_s[W-1], merged_min_s};
    counter_inc_s = (counter_r == CNT_MAX) ? counter_r : counter_r + CNT_ONE;
    timeout_s     = (cr_timeout != CNT_ZERO) && (counter_r >= cr_timeout);
  end

  // FSM next state, counter, trackers and result updates
  always_comb begin
    state_n_s   = state_r;
    counter_n_s = counter_r;
    max_n_s     = max_r;
    min_n_s     = min_r;
    valid_n_s   = 1'b0;
    period_n_s  = meas_period;
    mmax_n_s    = meas_max;
    mmin_n_s    = meas_min;
    p2p_n_s     = meas_p2p;
    lost_n_s    = signal_lost;
    case (state_r)
      SEEK: begin
        if (rise_s) begin
          state_n_s   = MEASURE;
          counter_n_s = CNT_ONE;
          max_n_s     = wave_sample;
          min_n_s     = wave_sample;
        end else begin
          state_n_s   = SEEK;
        end
      end
      MEASURE: begin
        // An edge landing on the timeout cycle still closes the period
        if (rise_s) begin
          valid_n_s   = 1'b1;
          period_n_s  = counter_r;
          mmax_n_s    = merged_max_s;
          mmin_n_s    = merged_min_s;
          p2p_n_s     = span_s;
          lost_n_s    = 1'b0;
          counter_n_s = CNT_ONE;
          max_n_s     = wave_sample;
          min_n_s     = wave_sample;
        end else if (timeout_s) begin
          state_n_s   = SEEK;
          counter_n_s = CNT_ZERO;
          lost_n_s    = 1'b1;
        end else begin
          counter_n_s = counter_inc_s;
          if (wave_valid) begin
            max_n_s = merged_max_s;
            min_n_s = merged_min_s;
          end else begin
            max_n_s = max_r;
            min_n_s = min_r;
          end
        end
      end
      default: begin
        state_n_s   = SEEK;
        counter_n_s = CNT_ZERO;
      end
    endcase
  end

  // State, counter, tracker and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SEEK;
      counter_r   <= CNT_ZERO;
      max_r       <= MAX_INIT;
      min_r       <= MIN_INIT;
      meas_valid  <= 1'b0;
      meas_period <= CNT_ZERO;
      meas_max    <= {W{1'b0}};
      meas_min    <= {W{1'b0}};
      meas_p2p    <= {(W+1){1'b0}};
      signal_lost <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      counter_r   <= counter_n_s;
      max_r       <= max_n_s;
      min_r       <= min_n_s;
      meas_valid  <= valid_n_s;
      meas_period <= period_n_s;
      meas_max    <= mmax_n_s;
      meas_min    <= mmin_n_s;
      meas_p2p    <= p2p_n_s;
      signal_lost <= lost_n_s;
    end
  end

endmodule

// File: tb/tb_osc_wave_analyzer.sv
// Self-checking bench for osc_wave_analyzer: timestamp-based reference model,
// directed waveforms from the datasheet plus randomized segments.
module tb_osc_wave_analyzer;

  localparam int W = 24;
  localparam int P = 32;
  localparam longint PMAX = 64'd4294967295;

  typedef struct packed {
    logic [31:0]         cyc;
    logic [P-1:0]        period;
    logic signed [W-1:0] mx;
    logic signed [W-1:0] mn;
    logic [W:0]          p2p;
  } rep_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [W-1:0] wave_sample;
  logic                wave_valid;
  logic [W-2:0]        cr_hysteresis;
  logic [P-1:0]        cr_timeout;
  logic                meas_valid;
  logic [P-1:0]        meas_period;
  logic signed [W-1:0] meas_max;
  logic signed [W-1:0] meas_min;
  logic [W:0]          meas_p2p;
  logic                signal_lost;

  int n_pass = 0;
  int n_total = 0;

  longint cyc = 0;
  bit     m_high, m_armed, m_lost, m_prev_lost, d_prev_lost;
  longint m_tprev, m_max, m_min;
  int     dut_lost_rises, exp_lost_rises;
  longint dut_lost_cyc, exp_lost_cyc;
  rep_t   dut_q[$];
  rep_t   exp_q[$];

  osc_wave_analyzer #(.WAVE_WIDTH_P(W), .PERIOD_WIDTH_P(P)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wave_sample   (wave_sample),
    .wave_valid    (wave_valid),
    .cr_hysteresis (cr_hysteresis),
    .cr_timeout    (cr_timeout),
    .meas_valid    (meas_valid),
    .meas_period   (meas_period),
    .meas_max      (meas_max),
    .meas_min      (meas_min),
    .meas_p2p      (meas_p2p),
    .signal_lost   (signal_lost)
  );

  always #5 clk = ~clk;

  // Reference: rising events are timestamped; a period is the gap between
  // consecutive events, extremes are taken over the samples in between.
  task automatic model_step(input longint s, input bit v);
    longint h, to, el, mx, mn;
    bit rise;
    rep_t r;
    h = longint'(cr_hysteresis);
    to = longint'(cr_timeout);
    rise = v && !m_high && (s >= h);
    if (rise) m_high = 1'b1;
    else if (v && m_high && s <= -h) m_high = 1'b0;
    if (m_armed) begin
      el = cyc - m_tprev;
      if (el > PMAX) el = PMAX;
      if (rise) begin
        mx = (s > m_max) ? s : m_max;
        mn = (s < m_min) ? s : m_min;
        r.cyc = 32'(cyc); r.period = 32'(el); r.mx = 24'(mx); r.mn = 24'(mn); r.p2p = 25'(mx - mn);
        exp_q.push_back(r);
        m_lost = 1'b0; m_tprev = cyc; m_max = s; m_min = s;
      end else if (to != 0 && el >= to) begin
        m_armed = 1'b0; m_lost = 1'b1;
      end else if (v) begin
        if (s > m_max) m_max = s;
        if (s < m_min) m_min = s;
      end
    end else if (rise) begin
      m_armed = 1'b1; m_tprev = cyc; m_max = s; m_min = s;
    end
    if (m_lost && !m_prev_lost) begin exp_lost_rises++; exp_lost_cyc = cyc; end
    m_prev_lost = m_lost;
  endtask

  // Drive one clock of stimulus, advance the model, log what the DUT reports
  task automatic cycle(input int s, input logic v);
    logic signed [W-1:0] s_w;
    rep_t r;
    s_w = s[W-1:0];
    wave_sample = s_w;
    wave_valid = v;
    @(posedge clk);
    cyc++;
    model_step(longint'(s_w), v);
    #1;
    if (meas_valid) begin
      r.cyc = 32'(cyc); r.period = meas_period; r.mx = meas_max; r.mn = meas_min; r.p2p = meas_p2p;
      dut_q.push_back(r);
    end
    if (signal_lost && !d_prev_lost) begin dut_lost_rises++; dut_lost_cyc = cyc; end
    d_prev_lost = signal_lost;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wave_valid = 1'b0; wave_sample = '0;
    m_high = 1'b0; m_armed = 1'b0; m_lost = 1'b0; m_prev_lost = 1'b0; d_prev_lost = 1'b0;
    dut_lost_rises = 0; exp_lost_rises = 0; dut_lost_cyc = -1; exp_lost_cyc = -1;
    dut_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int tri_sample(input int k);
    if (k <= 100) return -8388608 + k * 167772;
    else return 8388592 - (k - 100) * 167772;
  endfunction

  task automatic run_triangle(input int periods, input int decim);
    for (int p = 0; p < periods; p++)
      for (int k = 0; k < 200; k++) begin
        cycle(tri_sample(k), 1'b1);
        for (int d = 1; d < decim; d++) cycle(int'($urandom()), 1'b0);
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cr_hysteresis = '0; cr_timeout = '0; wave_valid = 1'b0; wave_sample = '0;
    #1;
    n_total++; if (meas_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", meas_valid); else n_pass++;
    n_total++; if (meas_period !== '0) $display("FAIL reset_period: got %0d want 0", meas_period); else n_pass++;
    n_total++; if (meas_max !== '0) $display("FAIL reset_max: got %0d want 0", meas_max); else n_pass++;
    n_total++; if (meas_min !== '0) $display("FAIL reset_min: got %0d want 0", meas_min); else n_pass++;
    n_total++; if (meas_p2p !== '0) $display("FAIL reset_p2p: got %0d want 0", meas_p2p); else n_pass++;
    n_total++; if (signal_lost !== 1'b0) $display("FAIL reset_lost: got %0b want 0", signal_lost); else n_pass++;
    do_reset();
  endtask

  task automatic test_triangle();
    do_reset();
    cr_hysteresis = 23'd1048576; cr_timeout = 32'd0;
    run_triangle(5, 1);
    n_total++; if (dut_q.size() != exp_q.size()) $display("FAIL tri_count: got %0d want %0d", dut_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (dut_q[i] !== exp_q[i]) $display("FAIL tri_report[%0d]: got %h want %h", i, dut_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (dut_q.size() != 4) $display("FAIL tri_reports: got %0d want 4", dut_q.size()); else n_pass++;
    if (dut_q.size() > 0) begin
      n_total++; if (dut_q[$].period !== 32'd200) $display("FAIL tri_period: got %0d want 200", dut_q[$].period); else n_pass++;
      n_total++; if (dut_q[$].mx !== 24'sd8388592) $display("FAIL tri_max: got %0d want 8388592", dut_q[$].mx); else n_pass++;
      n_total++; if (dut_q[$].mn !== -24'sd8388608) $display("FAIL tri_min: got %0d want -8388608", dut_q[$].mn); else n_pass++;
      n_total++; if (dut_q[$].p2p !== 25'd16777200) $display("FAIL tri_p2p: got %0d want 16777200", dut_q[$].p2p); else n_pass++;
    end
  endtask

  task automatic test_decimated();
    do_reset();
    cr_hysteresis = 23'd1048576; cr_timeout = 32'd0;
    run_triangle(5, 4);
    n_total++; if (dut_q.size() != exp_q.size()) $display("FAIL dec_count: got %0d want %0d", dut_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (dut_q[i] !== exp_q[i]) $display("FAIL dec_report[%0d]: got %h want %h", i, dut_q[i], exp_q[i]); else n_pass++;
    end
    if (dut_q.size() > 0) begin
      n_total++; if (dut_q[$].period !== 32'd800) $display("FAIL dec_period: got %0d want 800", dut_q[$].period); else n_pass++;
      n_total++; if (dut_q[$].p2p !== 25'd16777200) $display("FAIL dec_p2p: got %0d want 16777200", dut_q[$].p2p); else n_pass++;
    end
  endtask

  task automatic test_square();
    do_reset();
    cr_hysteresis = 23'd2000; cr_timeout = 32'd0;
    for (int k = 0; k < 400; k++) cycle(((k / 50) % 2 == 0) ? 1000 : -1000, 1'b1);
    n_total++; if (dut_q.size() != 0) $display("FAIL sq_quiet: got %0d reports want 0", dut_q.size()); else n_pass++;
    n_total++; if (signal_lost !== 1'b0) $display("FAIL sq_lost_off: got %0b want 0", signal_lost); else n_pass++;
    cr_hysteresis = 23'd500; cr_timeout = 32'd300;
    for (int k = 400; k < 700; k++) cycle(((k / 50) % 2 == 0) ? 1000 : -1000, 1'b1);
    n_total++; if (dut_q.size() != exp_q.size()) $display("FAIL sq_count: got %0d want %0d", dut_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (dut_q[i] !== exp_q[i]) $display("FAIL sq_report[%0d]: got %h want %h", i, dut_q[i], exp_q[i]); else n_pass++;
    end
    if (dut_q.size() > 0) begin
      n_total++; if (dut_q[$].period !== 32'd100) $display("FAIL sq_period: got %0d want 100", dut_q[$].period); else n_pass++;
    end
    n_total++; if (signal_lost !== 1'b0) $display("FAIL sq_lost: got %0b want 0", signal_lost); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    cr_hysteresis = 23'd1048576; cr_timeout = 32'd500;
    run_triangle(3, 1);
    for (int k = 0; k < 600; k++) cycle(0, 1'b1);
    n_total++; if (signal_lost !== 1'b1) $display("FAIL to_lost_set: got %0b want 1", signal_lost); else n_pass++;
    n_total++; if (dut_lost_cyc - m_tprev != 500) $display("FAIL to_lost_at: got %0d want 500", dut_lost_cyc - m_tprev); else n_pass++;
    run_triangle(3, 1);
    n_total++; if (dut_q.size() != exp_q.size()) $display("FAIL to_count: got %0d want %0d", dut_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (dut_q[i] !== exp_q[i]) $display("FAIL to_report[%0d]: got %h want %h", i, dut_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (dut_q.size() != 4) $display("FAIL to_reports: got %0d want 4", dut_q.size()); else n_pass++;
    n_total++; if (signal_lost !== 1'b0) $display("FAIL to_lost_clr: got %0b want 0", signal_lost); else n_pass++;
    n_total++; if (dut_lost_rises != 1) $display("FAIL to_lost_rises: got %0d want 1", dut_lost_rises); else n_pass++;
  endtask

  task automatic test_event_at_timeout();
    do_reset();
    cr_hysteresis = 23'd1048576; cr_timeout = 32'd200;
    run_triangle(3, 1);
    n_total++; if (dut_q.size() != 2) $display("FAIL eat_reports: got %0d want 2", dut_q.size()); else n_pass++;
    n_total++; if (dut_lost_rises != 0) $display("FAIL eat_lost: got %0d rises want 0", dut_lost_rises); else n_pass++;
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (dut_q[i] !== exp_q[i]) $display("FAIL eat_report[%0d]: got %h want %h", i, dut_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_threshold();
    int pat[9] = '{-1000, 1000, 999, -999, -1000, 1000, 999, -1000, 1000};
    do_reset();
    cr_hysteresis = 23'd1000; cr_timeout = 32'd0;
    for (int i = 0; i < 9; i++) repeat (3) cycle(pat[i], 1'b1);
    n_total++; if (dut_q.size() != 2) $display("FAIL thr_reports: got %0d want 2", dut_q.size()); else n_pass++;
    if (dut_q.size() == 2) begin
      n_total++; if (dut_q[0].period !== 32'd12) $display("FAIL thr_period0: got %0d want 12", dut_q[0].period); else n_pass++;
      n_total++; if (dut_q[1].period !== 32'd9) $display("FAIL thr_period1: got %0d want 9", dut_q[1].period); else n_pass++;
    end
  endtask

  task automatic test_noisy();
    int base;
    do_reset();
    cr_hysteresis = 23'd20000; cr_timeout = 32'd0;
    for (int p = 0; p < 7; p++)
      for (int k = 0; k < ((p == 6) ? 150 : 400); k++) begin
        base = (k < 200) ? (-100000 + k * 1000) : (100000 - (k - 200) * 1000);
        cycle(base + int'($urandom_range(0, 20000)) - 10000, 1'b1);
      end
    n_total++; if (dut_q.size() != 6) $display("FAIL noisy_reports: got %0d want 6", dut_q.size()); else n_pass++;
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (dut_q[i] !== exp_q[i]) $display("FAIL noisy_report[%0d]: got %h want %h", i, dut_q[i], exp_q[i]); else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_total++; if (meas_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b want 0", meas_valid); else n_pass++;
    n_total++; if (meas_period !== '0) $display("FAIL mid_rst_period: got %0d want 0", meas_period); else n_pass++;
    n_total++; if (meas_max !== '0) $display("FAIL mid_rst_max: got %0d want 0", meas_max); else n_pass++;
    n_total++; if (meas_min !== '0) $display("FAIL mid_rst_min: got %0d want 0", meas_min); else n_pass++;
    n_total++; if (meas_p2p !== '0) $display("FAIL mid_rst_p2p: got %0d want 0", meas_p2p); else n_pass++;
    do_reset();
    run_triangle(3, 1);
    n_total++; if (dut_q.size() != 2) $display("FAIL post_rst_reports: got %0d want 2", dut_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    int s, walk, mode;
    do_reset();
    walk = 0;
    for (int seg = 0; seg < 12; seg++) begin
      mode = seg % 3;
      cr_hysteresis = (mode == 2) ? 23'($urandom_range(0, 8388607)) : 23'($urandom_range(0, 3000));
      cr_timeout = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(20, 400));
      for (int k = 0; k < 350; k++) begin
        if (mode == 0) s = int'($urandom_range(0, 16000)) - 8000;
        else if (mode == 1) begin
          walk = walk + int'($urandom_range(0, 600)) - 300;
          if (walk > 20000) walk = 20000;
          if (walk < -20000) walk = -20000;
          s = walk;
        end else s = int'($urandom());
        cycle(s, $urandom_range(0, 3) != 0);
      end
    end
    n_total++; if (dut_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d want %0d", dut_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (dut_q[i] !== exp_q[i]) $display("FAIL rnd_report[%0d]: got %h want %h", i, dut_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (dut_lost_rises != exp_lost_rises) $display("FAIL rnd_lost_rises: got %0d want %0d", dut_lost_rises, exp_lost_rises); else n_pass++;
    n_total++; if (dut_lost_cyc != exp_lost_cyc) $display("FAIL rnd_lost_cyc: got %0d want %0d", dut_lost_cyc, exp_lost_cyc); else n_pass++;
    n_total++; if (signal_lost !== m_lost) $display("FAIL rnd_lost_final: got %0b want %0b", signal_lost, m_lost); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_decimated();
    test_square();
    test_timeout();
    test_event_at_timeout();
    test_threshold();
    test_noisy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
